// File: rtl/ahb_s_mem.sv
// AHB-Lite slave with word-addressed on-chip memory, programmable wait states
// and two-cycle ERROR response for misaligned, mis-sized or out-of-range accesses.
module ahb_s_mem #(
   parameter int               ADDRW       = 32,
   parameter int               DATAW       = 32,
   parameter int               DEPTH       = 256,
   parameter logic [ADDRW-1:0] BASE_ADDR   = '0,
   parameter int               WAIT_STATES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hsel,
   input  logic [ADDRW-1:0] haddr,
   input  logic [1:0]       htrans,
   input  logic             hwrite,
   input  logic [2:0]       hsize,
   input  logic [2:0]       hburst,
   input  logic [DATAW-1:0] hwdata,
   input  logic             hready,
   output logic             hreadyout,
   output logic             hresp,
   output logic [DATAW-1:0] hrdata,
   output logic [15:0]      xfer_cnt
);

   localparam int               IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDRW:0]   BASE_EXT  = {1'b0, BASE_ADDR};
   localparam logic [ADDRW:0]   SPAN      = (ADDRW + 1)'(4 * DEPTH);
   localparam logic [3:0]       WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [3:0]       r_wcnt;
   logic [3:0]       w_wcnt_next;
   logic [IDXW-1:0]  r_idx;
   logic [IDXW-1:0]  w_idx_next;
   logic             r_write;
   logic             w_write_next;
   logic [15:0]      r_xfer_cnt;
   logic [15:0]      w_xfer_cnt_next;

   logic [DATAW-1:0] r_mem [DEPTH];

   logic             w_ready;
   logic             w_accept;
   logic             w_err;
   logic [ADDRW:0]   w_diff;
   logic [IDXW-1:0]  w_idx_new;
   logic             w_wr_en;
   logic             w_unused;

   // Below-base addresses borrow into the top bit of w_diff, so a single
   // compare against SPAN catches both ends of the window.
   assign w_diff    = {1'b0, haddr} - BASE_EXT;
   assign w_idx_new = IDXW'(w_diff >> 2);
   assign w_err     = (hsize != 3'b010) || (haddr[1:0] != 2'b00) || (w_diff >= SPAN);

   assign w_ready   = (r_state != ST_WAIT) && (r_state != ST_ERR1);
   assign w_accept  = w_ready & hsel & hready & htrans[1];
   assign w_wr_en   = (r_state == ST_DATA) && r_write;
   assign w_unused  = ^{htrans[0], hburst};
   assign xfer_cnt  = r_xfer_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_IDLE;
         r_wcnt     <= 4'd0;
         r_idx      <= '0;
         r_write    <= 1'b0;
         r_xfer_cnt <= 16'd0;
      end else begin
         r_state    <= w_state_next;
         r_wcnt     <= w_wcnt_next;
         r_idx      <= w_idx_next;
         r_write    <= w_write_next;
         r_xfer_cnt <= w_xfer_cnt_next;
      end
   end

   // Write commits at the end of DATA, ahead of any pipelined read's DATA cycle.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_idx] <= hwdata;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_wcnt_next     = r_wcnt;
      w_idx_next      = r_idx;
      w_write_next    = r_write;
      w_xfer_cnt_next = r_xfer_cnt;
      hreadyout       = 1'b1;
      hresp           = 1'b0;
      hrdata          = '0;

      case (r_state)
         ST_WAIT: begin
            hreadyout = 1'b0;
            if (r_wcnt == 4'd0) begin
               w_state_next = ST_DATA;
            end else begin
               w_wcnt_next = r_wcnt - 4'd1;
            end
         end
         ST_ERR1: begin
            hreadyout    = 1'b0;
            hresp        = 1'b1;
            w_state_next = ST_ERR2;
         end
         default: begin
            if (r_state == ST_ERR2) begin
               hresp = 1'b1;
            end
            if (r_state == ST_DATA) begin
               w_xfer_cnt_next = r_xfer_cnt + 16'd1;
               if (!r_write) begin
                  hrdata = r_mem[r_idx];
               end
            end
            w_state_next = ST_IDLE;
            if (w_accept) begin
               w_idx_next   = w_idx_new;
               w_write_next = hwrite;
               if (w_err) begin
                  w_state_next = ST_ERR1;
               end else if (WAIT_STATES == 0) begin
                  w_state_next = ST_DATA;
               end else begin
                  w_state_next = ST_WAIT;
                  w_wcnt_next  = WCNT_INIT;
               end
            end
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_s_mem.sv
// Directed bench for ahb_s_mem: one instance with one wait state, one with none.
module tb_ahb_s_mem;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_BUSY = 2'b01;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // instance A: WAIT_STATES = 1
   logic        a_rst;
   logic        a_hsel;
   logic [31:0] a_haddr;
   logic [1:0]  a_htrans;
   logic        a_hwrite;
   logic [2:0]  a_hsize;
   logic [2:0]  a_hburst;
   logic [31:0] a_hwdata;
   logic        a_hready;
   logic        a_hreadyout;
   logic        a_hresp;
   logic [31:0] a_hrdata;
   logic [15:0] a_xfer_cnt;

   // instance B: WAIT_STATES = 0
   logic        b_rst;
   logic        b_hsel;
   logic [31:0] b_haddr;
   logic [1:0]  b_htrans;
   logic        b_hwrite;
   logic [2:0]  b_hsize;
   logic [2:0]  b_hburst;
   logic [31:0] b_hwdata;
   logic        b_hready;
   logic        b_hreadyout;
   logic        b_hresp;
   logic [31:0] b_hrdata;
   logic [15:0] b_xfer_cnt;

   assign a_hready = a_hreadyout;
   assign b_hready = b_hreadyout;

   ahb_s_mem #(.ADDRW(32), .DATAW(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_a (
      .clk(clk), .rst(a_rst), .hsel(a_hsel), .haddr(a_haddr), .htrans(a_htrans),
      .hwrite(a_hwrite), .hsize(a_hsize), .hburst(a_hburst), .hwdata(a_hwdata),
      .hready(a_hready), .hreadyout(a_hreadyout), .hresp(a_hresp), .hrdata(a_hrdata),
      .xfer_cnt(a_xfer_cnt)
   );

   ahb_s_mem #(.ADDRW(32), .DATAW(32), .DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_b (
      .clk(clk), .rst(b_rst), .hsel(b_hsel), .haddr(b_haddr), .htrans(b_htrans),
      .hwrite(b_hwrite), .hsize(b_hsize), .hburst(b_hburst), .hwdata(b_hwdata),
      .hready(b_hready), .hreadyout(b_hreadyout), .hresp(b_hresp), .hrdata(b_hrdata),
      .xfer_cnt(b_xfer_cnt)
   );

   typedef struct {
      logic [1:0]  trans;
      logic [2:0]  size;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          exp_lows;
      logic        exp_rlow;
      logic        exp_resp;
      logic [31:0] exp_rdata;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic [1:0] trans, input logic [2:0] size,
                               input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                               input int lows, input logic rlow, input logic resp,
                               input logic [31:0] rdata, input logic [15:0] cnt);
      vec_t v;
      v.trans = trans; v.size = size; v.addr = addr; v.wr = wr; v.wdata = wdata;
      v.exp_lows = lows; v.exp_rlow = rlow; v.exp_resp = resp;
      v.exp_rdata = rdata; v.exp_cnt = cnt;
      return v;
   endfunction

   function automatic logic [31:0] pat(input int i);
      return 32'hB000_0000 + (32'(i) * 32'h0001_0003);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   task automatic a_reset();
      a_rst = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      a_rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // Non-pipelined transfer on A: address phase, then wait out the data phase.
   task automatic a_single(input logic [1:0] trans, input logic [2:0] size,
                           input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           output int lows, output logic rlow, output logic resp,
                           output logic [31:0] rdata);
      a_hsel = 1'b1; a_htrans = trans; a_haddr = addr; a_hwrite = wr; a_hsize = size;
      @(posedge clk); #1;
      a_hsel = 1'b0; a_htrans = T_IDLE; a_hwdata = wdata;
      lows = 0;
      rlow = 1'b0;
      while (a_hreadyout !== 1'b1 && lows < 16) begin
         if (lows == 0) rlow = a_hresp;
         lows++;
         @(posedge clk); #1;
      end
      if (lows >= 16) begin
         errors++;
         $display("FAIL single_timeout addr=%08h actual=stuck required=ready", addr);
      end
      resp  = a_hresp;
      rdata = a_hrdata;
      @(posedge clk); #1;
      a_hwdata = '0;
   endtask

   // Pipelined INCR burst on A; returns cycles from first address phase to last data end.
   task automatic a_burst(input logic wr, input int n, input logic [31:0] base, output int cycles);
      int  issued;
      int  dp;
      int  done;
      logic adv;
      a_hsel = 1'b1; a_htrans = T_NSEQ; a_haddr = base; a_hwrite = wr;
      a_hsize = 3'b010; a_hburst = 3'b001;
      issued = 1; dp = -1; done = 0; cycles = 0;
      while (done < n && cycles < 4 * n + 20) begin
         if (dp >= 0) a_hwdata = wr ? pat(dp) : 32'h0;
         adv = a_hreadyout;
         if (adv && dp >= 0) begin
            if (!wr) chk($sformatf("burst_rd[%0d]", dp), a_hrdata, pat(dp));
            done++;
         end
         @(posedge clk); #1;
         cycles++;
         if (adv) begin
            dp = a_htrans[1] ? issued - 1 : -1;
            if (issued < n) begin
               a_htrans = T_SEQ;
               a_haddr  = base + 32'(4 * issued);
               issued++;
            end else begin
               a_hsel = 1'b0; a_htrans = T_IDLE;
            end
         end
      end
      a_hwdata = '0; a_hburst = 3'b000;
      $display("burst wr=%0d beats=%0d done=%0d cycles=%0d cnt=%0d", wr, n, done, cycles, a_xfer_cnt);
   endtask

   initial begin
      int          lows;
      logic        rlow;
      logic        resp;
      logic [31:0] rdata;
      int          cyc;

      a_rst = 1'b0; a_hsel = 1'b0; a_haddr = '0; a_htrans = T_IDLE; a_hwrite = 1'b0;
      a_hsize = 3'b010; a_hburst = 3'b000; a_hwdata = '0;
      b_rst = 1'b0; b_hsel = 1'b0; b_haddr = '0; b_htrans = T_IDLE; b_hwrite = 1'b0;
      b_hsize = 3'b010; b_hburst = 3'b000; b_hwdata = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_hreadyout", a_hreadyout, 1'b1);
      chk("rst_hresp", a_hresp, 1'b0);
      chk("rst_hrdata", a_hrdata, 32'h0);
      chk("rst_xfer_cnt", a_xfer_cnt, 16'h0);
      @(negedge clk);
      a_rst = 1'b1; b_rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_hreadyout", a_hreadyout, 1'b1);
      chk("idle_hresp", a_hresp, 1'b0);
      chk("idle_xfer_cnt", a_xfer_cnt, 16'h0);
      chk("idle_b_hreadyout", b_hreadyout, 1'b1);

      vt.push_back(mk(T_NSEQ, 3'b010, 32'h010, 1'b1, 32'hDEADBEEF, 1, 1'b0, 1'b0, 32'h0,        16'd1));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h010, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'hDEADBEEF, 16'd2));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h000, 1'b1, 32'h00000A0A, 1, 1'b0, 1'b0, 32'h0,        16'd3));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h3FC, 1'b1, 32'hCAFEF00D, 1, 1'b0, 1'b0, 32'h0,        16'd4));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h3FC, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'hCAFEF00D, 16'd5));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h402, 1'b1, 32'hBAD00001, 1, 1'b1, 1'b1, 32'h0,        16'd5));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h400, 1'b1, 32'hBAD00002, 1, 1'b1, 1'b1, 32'h0,        16'd5));
      vt.push_back(mk(T_NSEQ, 3'b001, 32'h010, 1'b1, 32'hBAD00003, 1, 1'b1, 1'b1, 32'h0,        16'd5));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h402, 1'b0, 32'h0,        1, 1'b1, 1'b1, 32'h0,        16'd5));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h010, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'hDEADBEEF, 16'd6));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h000, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'h00000A0A, 16'd7));
      vt.push_back(mk(T_IDLE, 3'b010, 32'h010, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'h0,        16'd7));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h200, 1'b1, 32'h11111111, 1, 1'b0, 1'b0, 32'h0,        16'd8));
      vt.push_back(mk(T_BUSY, 3'b010, 32'h204, 1'b1, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 32'h0,        16'd8));
      vt.push_back(mk(T_SEQ,  3'b010, 32'h204, 1'b1, 32'h22222222, 1, 1'b0, 1'b0, 32'h0,        16'd9));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h200, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'h11111111, 16'd10));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h204, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'h22222222, 16'd11));
      vt.push_back(mk(T_NSEQ, 3'b010, 32'h010, 1'b0, 32'h0,        1, 1'b0, 1'b0, 32'hDEADBEEF, 16'd12));

      foreach (vt[i]) begin
         a_single(vt[i].trans, vt[i].size, vt[i].addr, vt[i].wr, vt[i].wdata, lows, rlow, resp, rdata);
         $display("row %0d trans=%b size=%b addr=%08h wr=%0d lows=%0d resp=%0d rdata=%08h cnt=%0d",
                  i, vt[i].trans, vt[i].size, vt[i].addr, vt[i].wr, lows, resp, rdata, a_xfer_cnt);
         chk($sformatf("row%0d_lows", i), 32'(lows), 32'(vt[i].exp_lows));
         chk($sformatf("row%0d_resp_first", i), rlow, vt[i].exp_rlow);
         chk($sformatf("row%0d_resp_last", i), resp, vt[i].exp_resp);
         chk($sformatf("row%0d_rdata", i), rdata, vt[i].exp_rdata);
         chk($sformatf("row%0d_xfer_cnt", i), a_xfer_cnt, vt[i].exp_cnt);
      end

      // Reset while a write to 0x10 sits in WAIT: ready returns at once, word unchanged.
      a_hsel = 1'b1; a_htrans = T_NSEQ; a_haddr = 32'h10; a_hwrite = 1'b1; a_hsize = 3'b010;
      @(posedge clk); #1;
      a_hsel = 1'b0; a_htrans = T_IDLE; a_hwdata = 32'h55555555;
      chk("midwait_hreadyout_low", a_hreadyout, 1'b0);
      a_rst = 1'b0;
      #1;
      chk("midwait_rst_hreadyout", a_hreadyout, 1'b1);
      chk("midwait_rst_hresp", a_hresp, 1'b0);
      chk("midwait_rst_xfer_cnt", a_xfer_cnt, 16'h0);
      @(negedge clk);
      a_rst = 1'b1; a_hwdata = '0;
      @(posedge clk); #1;
      a_single(T_NSEQ, 3'b010, 32'h10, 1'b0, 32'h0, lows, rlow, resp, rdata);
      $display("midwait readback addr=00000010 rdata=%08h cnt=%0d", rdata, a_xfer_cnt);
      chk("midwait_word_kept", rdata, 32'hDEADBEEF);
      chk("midwait_readback_cnt", a_xfer_cnt, 16'd1);

      a_reset();
      a_burst(1'b1, 96, 32'h40, cyc);
      chk("burst_wr_cycles", 32'(cyc), 32'd193);
      a_burst(1'b0, 96, 32'h40, cyc);
      chk("burst_rd_cycles", 32'(cyc), 32'd193);
      chk("burst_xfer_cnt", a_xfer_cnt, 16'd192);

      // Zero-wait pipelined write then read of 0x20 on B.
      b_hsel = 1'b1; b_htrans = T_NSEQ; b_haddr = 32'h20; b_hwrite = 1'b1; b_hsize = 3'b010;
      @(posedge clk); #1;
      chk("b_wr_zero_wait", b_hreadyout, 1'b1);
      b_hwdata = 32'h600DF00D; b_hwrite = 1'b0;
      @(posedge clk); #1;
      $display("b pipelined rd addr=00000020 rdata=%08h cnt=%0d", b_hrdata, b_xfer_cnt);
      chk("b_rd_zero_wait", b_hreadyout, 1'b1);
      chk("b_rd_data", b_hrdata, 32'h600DF00D);
      chk("b_rd_resp", b_hresp, 1'b0);
      b_hsel = 1'b0; b_htrans = T_IDLE; b_hwdata = '0;
      @(posedge clk); #1;
      chk("b_idle_rdata", b_hrdata, 32'h0);
      chk("b_xfer_cnt_2", b_xfer_cnt, 16'd2);

      // Stream reads until the counter sits at FFFF, then one beat more wraps it.
      b_hsel = 1'b1; b_htrans = T_NSEQ; b_haddr = 32'h20; b_hwrite = 1'b0;
      repeat (65533) @(posedge clk);
      #1;
      b_hsel = 1'b0; b_htrans = T_IDLE;
      @(posedge clk); #1;
      $display("b stream done cnt=%04h", b_xfer_cnt);
      chk("b_xfer_cnt_ffff", b_xfer_cnt, 16'hFFFF);
      b_hsel = 1'b1; b_htrans = T_NSEQ;
      @(posedge clk); #1;
      chk("b_wrap_rdata", b_hrdata, 32'h600DF00D);
      b_hsel = 1'b0; b_htrans = T_IDLE;
      @(posedge clk); #1;
      $display("b wrap beat cnt=%04h", b_xfer_cnt);
      chk("b_xfer_cnt_wrap", b_xfer_cnt, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_s_mem.md
Name: ahb_s_mem

Overview:
AHB-Lite slave with word-addressed on-chip memory. It sits directly downstream of ahb_m and consumes the NONSEQ/SEQ transfers that ahb_m issues for each req/byte_cnt burst. It inserts a programmable number of wait states, so it is the source of the hready that ahb_m sees. It flags illegal accesses with the two-cycle AHB ERROR response.

Parameters:
ADDRW, 32, address width
DATAW, 32, data width (word = DATAW/8 bytes)
DEPTH, 256, memory depth in words
BASE_ADDR, 0, byte address of word 0
WAIT_STATES, 1, wait cycles per OKAY data phase (0..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
hsel  in  1  slave select
haddr  in  ADDRW  byte address (address phase)
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  in  1  1 = write
hsize  in  3  transfer size; only 3'b010 is legal
hburst  in  3  burst type; accepted, not checked
hwdata  in  DATAW  write data (data phase)
hready  in  1  bus-level ready (previous data phase complete)
hreadyout  out  1  slave ready / data phase end
hresp  out  1  0 OKAY, 1 ERROR
hrdata  out  DATAW  read data
xfer_cnt  out  16  completed OKAY beats, wraps

Behaviour:
- Reset (rst=0, asynchronous): hreadyout=1, hresp=0, hrdata=0, xfer_cnt=0, FSM=IDLE, pending address/control cleared. Memory contents are not reset.
- Reset mid-transfer aborts the transfer. A pending write is discarded and no memory word changes.
- Address phase accept: hsel & hready & htrans[1] at a rising edge. On accept, register addr_q, write_q, and err_q.
- err_q=1 under any of these conditions:
  - hsize != 3'b010
  - haddr[1:0] != 0
  - haddr < BASE_ADDR
  - haddr >= BASE_ADDR + 4*DEPTH
- IDLE, BUSY, or hsel=0 with hready=1: no transfer. The next cycle is a zero-wait OKAY (hreadyout=1, hresp=0).
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
    - Accepted with err_q=1 -> ERR1.
    - Accepted with WAIT_STATES=0 -> DATA.
    - Otherwise accepted -> WAIT, with wcnt=WAIT_STATES-1.
  - WAIT: hreadyout=0, hresp=0. Decrement wcnt; at wcnt=0 -> DATA.
  - DATA: hreadyout=1, hresp=0; this is the final data-phase cycle.
    - Write: mem[idx]<=hwdata at this edge.
    - Read: hrdata=mem[idx].
    - xfer_cnt increments (16-bit wrap, FFFF->0000).
    - A new accepted address phase in the same cycle is pipelined -> WAIT/DATA/ERR1 as from IDLE. With no new transfer -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. No memory access, xfer_cnt unchanged. Next state -> IDLE, or pipelines a new accept.
- idx = (addr_q - BASE_ADDR) >> 2, truncated to clog2(DEPTH) bits.
- hrdata is driven from mem[idx] only in DATA for reads. It is 0 in all other cycles.
- Back-to-back write then read of the same address returns the new data, because the write commits at the end of its DATA cycle, before the read's DATA cycle.
- While hreadyout=0, inputs other than hwdata are ignored; no new address phase is accepted.
- Latency per OKAY beat = WAIT_STATES+1 cycles from accept edge to data-phase end.
- Latency per ERROR = 2 cycles.

Test Plan:
- Reset, then apply no stimulus -> hreadyout=1, hresp=0, hrdata=0, xfer_cnt=0. Assert rst=0 mid-WAIT -> hreadyout=1 immediately and the target word is unchanged.
- WAIT_STATES=1: single NONSEQ write 0xDEADBEEF to 0x10, then NONSEQ read of 0x10 -> each beat has hreadyout low for 1 cycle, read returns 0xDEADBEEF, xfer_cnt=2.
- INCR burst of 96 words from 0x40 (NONSEQ then SEQ, 384 bytes), then read back -> each beat takes 2 cycles, data matches, xfer_cnt=192.
- WAIT_STATES=0: pipelined write/read to 0x20 on consecutive cycles -> zero wait states, read data equals write data.
- Illegal accesses -> ERROR (hresp=1 with hreadyout 0 then 1), no memory change, xfer_cnt unchanged:
  - haddr=0x402 (unaligned)
  - haddr=0x400 (out of range)
  - hsize=3'b001
- BUSY inserted mid-burst, and IDLE with hsel=1 -> zero-wait OKAY, no memory access. Preload xfer_cnt to 0xFFFF via 65535 beats, then one more beat -> wraps to 0x0000.
